// File: rtl/uart_tx_dev.sv
// Bus-mapped 8N1 UART transmitter with TX FIFO, divisor and drain irq.
// Define UART_TX_PARITY_EN to add the optional parity bit (CTRL[2:1]).
module uart_tx_dev #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd15
) (
   input  logic        clk_in,
   input  logic        sys_rstn,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic        re,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        uart_txd,
   output logic        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t state_q, state_d;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [3:0]    cnt4;
   logic          full, empty;
   logic          push_req, push, pop;
   logic          sts_wr, div_wr, ctl_wr;
   logic          ovf_q;

   logic [15:0]   div_reg, div_q;
   logic [15:0]   bcnt_q, bcnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    byte_q;
   logic          tick;
   logic          txd_d, txd_q, irq_q;
   logic          irq_en_q;
   logic          unused_bits;

`ifdef UART_TX_PARITY_EN
   logic par_on_r, odd_r;
   logic par_on_q, odd_q;
`endif

   assign push_req = we && (addr == 2'd0);
   assign sts_wr   = we && (addr == 2'd1);
   assign div_wr   = we && (addr == 2'd2);
   assign ctl_wr   = we && (addr == 2'd3);

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign pop   = (state_q == S_IDLE) && !empty;
   // a pop in the same cycle frees the slot for a push into a full FIFO
   assign push  = push_req && (!full || pop);
   assign cnt4  = 4'(count);
   assign tick  = (bcnt_q == div_q);

   assign uart_txd    = txd_q;
   assign irq         = irq_q;
   assign unused_bits = ^{re, wdata[31:16]};

   always_ff @(posedge clk_in) begin
      if (push) mem[wr_ptr] <= wdata[7:0];
   end

   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         if (push_req && !push)
            ovf_q <= 1'b1;
         else if (sts_wr && wdata[3])
            ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         div_reg  <= DIV_RESET;
         irq_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_on_r <= 1'b0;
         odd_r    <= 1'b0;
`endif
      end else begin
         if (div_wr) div_reg <= wdata[15:0];
         if (ctl_wr) begin
            irq_en_q <= wdata[0];
`ifdef UART_TX_PARITY_EN
            par_on_r <= wdata[1];
            odd_r    <= wdata[2];
`endif
         end
      end
   end

   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q <= S_IDLE;
         bcnt_q  <= '0;
         idx_q   <= '0;
         byte_q  <= '0;
         div_q   <= '0;
         txd_q   <= 1'b1;
         irq_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_on_q <= 1'b0;
         odd_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
         irq_q   <= irq_en_q && empty && (state_q == S_IDLE);
         // frame settings are frozen for the whole frame
         if (pop) begin
            byte_q <= mem[rd_ptr];
            div_q  <= div_reg;
`ifdef UART_TX_PARITY_EN
            par_on_q <= par_on_r;
            odd_q    <= odd_r;
`endif
         end
      end
   end

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q + 16'd1;
      idx_d   = idx_q;
      txd_d   = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            bcnt_d = '0;
            idx_d  = '0;
            if (!empty) state_d = S_START;
         end
         S_START: begin
            txd_d = 1'b0;
            if (tick) begin
               bcnt_d  = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            txd_d = byte_q[idx_q];
            if (tick) begin
               bcnt_d = '0;
               idx_d  = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = par_on_q ? S_PARITY : S_STOP;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            txd_d = (^byte_q) ^ odd_q;
            if (tick) begin
               bcnt_d  = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               bcnt_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            bcnt_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      rdata = '0;
      unique case (addr)
         2'd1: rdata[7:0] = {cnt4, ovf_q, empty, full,
                             (state_q != S_IDLE)};
         2'd2: rdata[15:0] = div_reg;
         2'd3: begin
            rdata[0] = irq_en_q;
`ifdef UART_TX_PARITY_EN
            rdata[2:1] = {odd_r, par_on_r};
`endif
         end
         default: rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Randomised self-checking bench for uart_tx_dev: line decoder and
// waveform model derived from the 8N1 frame rules.
module tb_uart_tx_dev;

   logic        clk_in = 1'b0;
   logic        sys_rstn = 1'b0;
   logic [1:0]  addr = '0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        uart_txd;
   logic        irq;

   int n_err = 0;
   int n_chk = 0;
   logic [7:0] bytes [16];

   uart_tx_dev dut (
      .clk_in   (clk_in),
      .sys_rstn (sys_rstn),
      .addr     (addr),
      .we       (we),
      .re       (re),
      .wdata    (wdata),
      .rdata    (rdata),
      .uart_txd (uart_txd),
      .irq      (irq)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(negedge clk_in);
      we    = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a,
                         input logic [31:0] exp);
      addr = a;
      re   = 1'b1;
      #1;
      check(tag, rdata, exp);
      re   = 1'b0;
   endtask

   // Line level t clocks after the DATA write, from the frame rules.
   function automatic logic exp_txd(input logic [7:0] b, input int div,
                                    input bit par, input bit odd,
                                    input int t);
      int k;
      if (t < 2) return 1'b1;
      k = (t - 2) / (div + 1);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (par && k == 9) return (^b) ^ odd;
      return 1'b1;
   endfunction

   task automatic wave(input string tag, input logic [7:0] b,
                       input int div, input bit par, input bit odd,
                       input int nsamp);
      wr(2'd0, {24'h0, b});
      for (int t = 0; t < nsamp; t++) begin
         if (t > 0) @(negedge clk_in);
         check(tag, uart_txd, exp_txd(b, div, par, odd, t));
      end
   endtask

   // Decode one frame by sampling each bit at its centre.
   task automatic rx(input int div, input bit par, input bit odd,
                     output logic [7:0] b);
      int n = 0;
      b = '0;
      while (uart_txd !== 1'b0 && n < 4000) begin
         @(negedge clk_in);
         n++;
      end
      if (n >= 4000) begin
         check("rx_timeout", 32'd1, 32'd0);
         return;
      end
      repeat (div / 2) @(negedge clk_in);
      for (int k = 0; k < 8; k++) begin
         repeat (div + 1) @(negedge clk_in);
         b[k] = uart_txd;
      end
      if (par) begin
         repeat (div + 1) @(negedge clk_in);
         check("rx_parity", uart_txd, (^b) ^ odd);
      end
      repeat (div + 1) @(negedge clk_in);
      check("rx_stop", uart_txd, 1'b1);
   endtask

   task automatic quiet(input string tag, input int n);
      int z = 0;
      repeat (n) begin
         @(negedge clk_in);
         if (uart_txd !== 1'b1) z++;
      end
      check(tag, z, 0);
   endtask

   task automatic burst(input int n, input int div);
      logic [7:0] got;
      fork
         begin
            for (int i = 0; i < n; i++)
               wr(2'd0, {24'h0, bytes[i]});
         end
         begin
            for (int i = 0; i < n; i++) begin
               rx(div, 1'b0, 1'b0, got);
               check("rx_byte", got, bytes[i]);
            end
         end
      join
   endtask

   initial begin
      int div;
      int n;
      logic [7:0] got;

      repeat (3) @(negedge clk_in);
      check("rst_txd", uart_txd, 1'b1);
      check("rst_irq", irq, 1'b0);
      sys_rstn = 1'b1;
      @(negedge clk_in);
      check("rst_txd2", uart_txd, 1'b1);
      rd_chk("rst_status", 2'd1, 32'h4);
      rd_chk("rst_div", 2'd2, 32'hF);
      rd_chk("rst_ctrl", 2'd3, 32'h0);
      rd_chk("data_rd", 2'd0, 32'h0);

      wr(2'd2, 32'hFFFF_0003);
      rd_chk("div_rd", 2'd2, 32'h3);
      wave("wave55", 8'h55, 3, 1'b0, 1'b0, 46);
      rd_chk("idle_status", 2'd1, 32'h4);

`ifdef UART_TX_PARITY_EN
      wr(2'd3, 32'h7);
      rd_chk("ctrl_par", 2'd3, 32'h7);
`else
      wr(2'd3, 32'h7);
      rd_chk("ctrl_nopar", 2'd3, 32'h1);
`endif
      wr(2'd3, 32'h1);
      @(negedge clk_in);
      check("irq_idle", irq, 1'b1);
      wr(2'd0, 32'hA3);
      check("irq_wr", irq, 1'b1);
      @(negedge clk_in);
      check("irq_drop", irq, 1'b0);
      repeat (40) @(negedge clk_in);
      check("irq_stop", irq, 1'b0);
      @(negedge clk_in);
      check("irq_rise", irq, 1'b1);
      wr(2'd3, 32'h0);

      wr(2'd2, 32'h0);
      for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
      fork
         begin
            for (int i = 0; i < 10; i++)
               wr(2'd0, {24'h0, bytes[i]});
            rd_chk("ovf_status", 2'd1, 32'h8B);
         end
         begin
            for (int i = 0; i < 9; i++) begin
               rx(0, 1'b0, 1'b0, got);
               check("ovf_byte", got, bytes[i]);
            end
         end
      join
      quiet("no_10th", 40);
      rd_chk("ovf_sticky", 2'd1, 32'hC);
      wr(2'd1, 32'h8);
      rd_chk("ovf_clr", 2'd1, 32'h4);

      wr(2'd2, 32'h3);
      wr(2'd0, 32'h3C);
      wr(2'd0, 32'h11);
      wr(2'd0, 32'h22);
      repeat (14) @(negedge clk_in);
      sys_rstn = 1'b0;
      #1;
      check("mid_rst_txd", uart_txd, 1'b1);
      check("mid_rst_irq", irq, 1'b0);
      rd_chk("mid_rst_sts", 2'd1, 32'h4);
      rd_chk("mid_rst_div", 2'd2, 32'hF);
      @(negedge clk_in);
      sys_rstn = 1'b1;
      @(negedge clk_in);
      wr(2'd2, 32'h2);
      bytes[0] = 8'h96;
      burst(1, 2);
      quiet("post_rst_quiet", 60);

      for (int r = 0; r < 6; r++) begin
         div = $urandom_range(0, 5);
         n   = $urandom_range(1, 9);
         for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
         wr(2'd2, div);
         burst(n, div);
         repeat (div + 4) @(negedge clk_in);
         rd_chk("rnd_drain", 2'd1, 32'h4);
      end

`ifdef UART_TX_PARITY_EN
      wr(2'd2, 32'h1);
      wr(2'd3, 32'h3);
      wave("par_even", 8'h07, 1, 1'b1, 1'b0, 28);
      wr(2'd3, 32'h7);
      wave("par_odd", 8'h07, 1, 1'b1, 1'b1, 28);
      wr(2'd3, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
